sha256_msg_schedule: RTL

Message-schedule stage of the SHA-256 core. It accepts one 512-bit padded block and streams the 64 schedule words W0..W63, one per accepted round, to the compression round logic. The compression stage is driven by the round counter. Internally it holds a 16-word sliding window and produces W16..W63 on the fly.

---
 rtl/sha256_msg_schedule.sv | 107 ++++++++++
 1 files changed

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule: SHA-256 message schedule; streams W0..W(NUM_ROUNDS-1) for one 512-bit block.
// Latency: block accepted at edge k, W0 valid in cycle k+1, then one word per accepted handshake.
// Backpressure: w_ready low freezes all outputs; blk_ready is high only while idle.
// Optional: define SHA256_SCHED_BSWAP_EN to byte-reverse each 32-bit input word on load.
module sha256_msg_schedule #(
  parameter int NUM_ROUNDS = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         abort,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_data,
  output logic [5:0]   w_idx,
  output logic         w_last,
  output logic         done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);

  state_t      state;
  logic [31:0] window [16];
  logic [31:0] next_word;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Input word ordering: big-endian by default, byte-reversed for little-endian sources.
  function automatic logic [31:0] load_word(input logic [31:0] w);
`ifdef SHA256_SCHED_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // Lookahead word entering the top of the window; still computed past W63 but never emitted.
  always_comb begin
    next_word = sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0];
  end

  assign w_data = window[0];
  assign w_last = w_valid && (w_idx == LAST_IDX);

  // Control FSM with registered handshake outputs, plus the sliding 16-word window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      w_idx     <= '0;
      w_valid   <= 1'b0;
      blk_ready <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < 16; i++) window[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          blk_ready <= 1'b1;
          if (blk_valid && blk_ready && !abort) begin
            for (int i = 0; i < 16; i++) window[i] <= load_word(blk_data[511-32*i -: 32]);
            w_idx     <= '0;
            w_valid   <= 1'b1;
            blk_ready <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            // Cancel wins over a simultaneous handshake; no completion pulse.
            state     <= IDLE;
            w_idx     <= '0;
            w_valid   <= 1'b0;
            blk_ready <= 1'b1;
          end else if (w_ready) begin
            if (w_idx == LAST_IDX) begin
              state     <= IDLE;
              w_idx     <= '0;
              w_valid   <= 1'b0;
              blk_ready <= 1'b1;
              done      <= 1'b1;
            end else begin
              for (int i = 0; i < 15; i++) window[i] <= window[i+1];
              window[15] <= next_word;
              w_idx      <= w_idx + 6'd1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          w_valid   <= 1'b0;
          blk_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
